// File: rtl/tx_frag_buffer_reader_if.sv
// Buffer-side and fragment-side signals of tx_frag_buffer_reader.
// master = the reader block, slave = the buffer/downstream side.
interface tx_frag_buffer_reader_if #(
  parameter int BEAT_DW  = 8,
  parameter int DW_WIDTH = 32
);
  localparam int CW = $clog2(BEAT_DW) + 1;

  logic [DW_WIDTH-1:0]    data_out;
  logic                   empty_buffer;
  logic                   rd_en;
  logic [BEAT_DW*32-1:0]  frag_data;
  logic                   frag_valid;
  logic                   frag_ready;
  logic                   frag_sop;
  logic                   frag_eop;
  logic [CW-1:0]          frag_dw_cnt;

  modport master (
    input  data_out, empty_buffer, frag_ready,
    output rd_en, frag_data, frag_valid, frag_sop, frag_eop, frag_dw_cnt
  );

  modport slave (
    output data_out, empty_buffer, frag_ready,
    input  rd_en, frag_data, frag_valid, frag_sop, frag_eop, frag_dw_cnt
  );
endinterface

// File: rtl/tx_frag_buffer_reader.sv
// Pops TLP DWs from a show-ahead buffer and packs them into BEAT_DW-wide beats.
// Optional FRAG_ECRC_EN: a header with TD=1 carries one extra digest DW.
module tx_frag_buffer_reader #(
  parameter int BEAT_DW  = 8,
  parameter int DW_WIDTH = 32
) (
  input logic                     clk,
  input logic                     rst,
  tx_frag_buffer_reader_if.master bus
);
  localparam int IW = $clog2(BEAT_DW);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(BEAT_DW);

  typedef enum logic {S_HDR, S_BODY} state_e;
  typedef logic [BEAT_DW-1:0][DW_WIDTH-1:0] beat_t;

  state_e        state_q, state_d;
  logic [10:0]   rem_q, rem_d;
  beat_t         asm_q, asm_d;
  logic [CW-1:0] asm_cnt_q, asm_cnt_d;
  logic          asm_closed_q, asm_closed_d;
  logic          asm_sop_q, asm_sop_d;
  logic          asm_eop_q, asm_eop_d;
  beat_t         out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic          out_free, xfer, rd_en, last_dw;
  logic [IW-1:0] slot;
  logic [10:0]   data_dw, hdr_total;

  // TLP length in DWs from the header DW currently at the buffer head
  always_comb begin
    data_dw = 11'd0;
    if (bus.data_out[30])
      data_dw = (bus.data_out[9:0] == 10'd0) ? 11'd1024 : {1'b0, bus.data_out[9:0]};
    hdr_total = (bus.data_out[29] ? 11'd4 : 11'd3) + data_dw;
`ifdef FRAG_ECRC_EN
    hdr_total = hdr_total + {10'd0, bus.data_out[15]};
`endif
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    asm_d        = asm_q;
    asm_cnt_d    = asm_cnt_q;
    asm_closed_d = asm_closed_q;
    asm_sop_d    = asm_sop_q;
    asm_eop_d    = asm_eop_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_cnt_d    = out_cnt_q;
    last_dw      = 1'b0;
    slot         = '0;

    out_free = !out_valid_q || bus.frag_ready;
    xfer     = asm_closed_q && out_free;
    // A closed beat leaving this cycle frees slot 0, so packing continues without a bubble
    rd_en    = !rst && !bus.empty_buffer && (!asm_closed_q || out_free);

    if (out_valid_q && bus.frag_ready) out_valid_d = 1'b0;

    if (xfer) begin
      out_data_d   = asm_q;
      out_valid_d  = 1'b1;
      out_sop_d    = asm_sop_q;
      out_eop_d    = asm_eop_q;
      out_cnt_d    = asm_cnt_q;
      asm_d        = '0;
      asm_cnt_d    = '0;
      asm_closed_d = 1'b0;
      asm_sop_d    = 1'b0;
      asm_eop_d    = 1'b0;
    end

    if (rd_en) begin
      slot        = asm_cnt_d[IW-1:0];
      asm_d[slot] = bus.data_out;
      asm_cnt_d   = asm_cnt_d + CW'(1);
      unique case (state_q)
        S_HDR: begin
          asm_sop_d = 1'b1;
          rem_d     = hdr_total - 11'd1;
          state_d   = S_BODY;
        end
        S_BODY: begin
          rem_d = rem_q - 11'd1;
          if (rem_q == 11'd1) begin
            last_dw = 1'b1;
            state_d = S_HDR;
          end
        end
        default: state_d = S_HDR;
      endcase
      asm_eop_d = last_dw;
      if (last_dw || asm_cnt_d == CNT_FULL) asm_closed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR;
      rem_q        <= '0;
      asm_q        <= '0;
      asm_cnt_q    <= '0;
      asm_closed_q <= 1'b0;
      asm_sop_q    <= 1'b0;
      asm_eop_q    <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      asm_q        <= asm_d;
      asm_cnt_q    <= asm_cnt_d;
      asm_closed_q <= asm_closed_d;
      asm_sop_q    <= asm_sop_d;
      asm_eop_q    <= asm_eop_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  assign bus.rd_en       = rd_en;
  assign bus.frag_data   = out_data_q;
  assign bus.frag_valid  = out_valid_q;
  assign bus.frag_sop    = out_sop_q;
  assign bus.frag_eop    = out_eop_q;
  assign bus.frag_dw_cnt = out_cnt_q;
endmodule

// File: tb/tb_tx_frag_buffer_reader.sv
// Bench for tx_frag_buffer_reader: TLP-level model chops each TLP into beats,
// a show-ahead buffer queue feeds the DUT, accepted beats are scoreboarded.
module tb_tx_frag_buffer_reader;
  localparam int BDW = 8;
`ifdef FRAG_ECRC_EN
  localparam int ECRC = 1;
`else
  localparam int ECRC = 0;
`endif

  typedef struct {
    logic [BDW*32-1:0] data;
    logic              sop;
    logic              eop;
    int                cnt;
  } beat_t;

  typedef struct {
    string       nm;
    logic [31:0] hdr;
    int          exp_total;
    int          exp_beats;
    int          exp_last_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_frag_buffer_reader_if #(.BEAT_DW(BDW), .DW_WIDTH(32)) bus ();
  tx_frag_buffer_reader #(.BEAT_DW(BDW), .DW_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          cyc_used = 0;
  logic [31:0] buf_q[$];
  beat_t       got[$];
  beat_t       exp_q[$];
  bit          hold_pend = 1'b0;
  beat_t       held;
  vec_t        vecs[7];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [BDW*32-1:0] act, input logic [BDW*32-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // TLP size in DWs straight from the header fields
  function automatic int tlp_total(input logic [31:0] h);
    int t;
    t = h[29] ? 4 : 3;
    if (h[30]) t += (h[9:0] == 10'd0) ? 1024 : int'(h[9:0]);
    if (ECRC == 1 && h[15]) t += 1;
    return t;
  endfunction

  task automatic add_tlp(input logic [31:0] h);
    int          t;
    logic [31:0] dws[$];
    beat_t       b;
    t = tlp_total(h);
    dws.push_back(h);
    for (int i = 1; i < t; i++) dws.push_back($urandom);
    foreach (dws[i]) buf_q.push_back(dws[i]);
    for (int s = 0; s < t; s += BDW) begin
      int n;
      n = (t - s < BDW) ? t - s : BDW;
      b.data = '0;
      for (int k = 0; k < n; k++) b.data[k*32 +: 32] = dws[s+k];
      b.sop = (s == 0);
      b.eop = (s + n == t);
      b.cnt = n;
      exp_q.push_back(b);
    end
  endtask

  task automatic step(input int rdy_pct, input int gap_pct);
    beat_t cur;
    @(negedge clk);
    bus.frag_ready   = (int'($urandom_range(99)) < rdy_pct);
    bus.empty_buffer = (buf_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    if (bus.empty_buffer) bus.data_out = $urandom;
    else                  bus.data_out = buf_q[0];
    #1;
    cur.data = bus.frag_data;
    cur.sop  = bus.frag_sop;
    cur.eop  = bus.frag_eop;
    cur.cnt  = int'(bus.frag_dw_cnt);
    if (hold_pend) begin
      chk("hold_valid", bus.frag_valid, 1);
      chk_vec("hold_data", cur.data, held.data);
      chk("hold_sop", cur.sop, held.sop);
      chk("hold_eop", cur.eop, held.eop);
      chk("hold_cnt", cur.cnt, held.cnt);
    end
    if (bus.empty_buffer) chk("rd_en_when_empty", bus.rd_en, 0);
    if (bus.rd_en && buf_q.size() != 0) begin
      void'(buf_q.pop_front());
      pops++;
    end
    if (bus.frag_valid && bus.frag_ready) got.push_back(cur);
    hold_pend = bus.frag_valid && !bus.frag_ready;
    held      = cur;
    cyc_used++;
  endtask

  task automatic drain(input int rdy_pct, input int gap_pct, input int budget);
    cyc_used = 0;
    while ((buf_q.size() != 0 || got.size() < exp_q.size()) && cyc_used < budget)
      step(rdy_pct, gap_pct);
    chk("buffer_left", buf_q.size(), 0);
  endtask

  task automatic compare_all(input string nm);
    int n;
    chk({nm, "_beat_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk_vec({nm, "_data"}, got[i].data, exp_q[i].data);
      chk({nm, "_sop"}, got[i].sop, exp_q[i].sop);
      chk({nm, "_eop"}, got[i].eop, exp_q[i].eop);
      chk({nm, "_cnt"}, got[i].cnt, exp_q[i].cnt);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst              = 1'b1;
    bus.empty_buffer = 1'b0;
    bus.data_out     = $urandom;
    bus.frag_ready   = 1'b1;
    #1 chk("rst_rd_en", bus.rd_en, 0);
    @(negedge clk);
    #1;
    chk("rst_rd_en2", bus.rd_en, 0);
    chk("rst_valid", bus.frag_valid, 0);
    chk("rst_sop", bus.frag_sop, 0);
    chk("rst_eop", bus.frag_eop, 0);
    chk("rst_cnt", bus.frag_dw_cnt, 0);
    chk_vec("rst_data", bus.frag_data, '0);
    rst              = 1'b0;
    bus.empty_buffer = 1'b1;
    hold_pend        = 1'b0;
  endtask

  initial begin
    logic [31:0] h;
    bus.data_out     = '0;
    bus.empty_buffer = 1'b1;
    bus.frag_ready   = 1'b0;

    vecs[0] = '{"mrd3_len1",  32'h0000_0001, 3,        1,   3};
    vecs[1] = '{"mwr4_len10", 32'h6000_000A, 14,       2,   6};
    vecs[2] = '{"mwr3_len0",  32'h4000_0000, 1027,     129, 3};
    vecs[3] = '{"mwr3_td",    32'h4000_8001, 4 + ECRC, 1,   4 + ECRC};
    vecs[4] = '{"mrd4",       32'h2000_0005, 4,        1,   4};
    vecs[5] = '{"mwr3_len5",  32'h4000_0005, 8,        1,   8};
    vecs[6] = '{"mwr4_len5",  32'h6000_0005, 9,        2,   1};

    do_reset();

    // Directed single-TLP vectors, ready held high, no buffer gaps
    for (int v = 0; v < 7; v++) begin
      pops = 0;
      add_tlp(vecs[v].hdr);
      drain(100, 0, 3000);
      chk({vecs[v].nm, "_pops"}, pops, vecs[v].exp_total);
      chk({vecs[v].nm, "_beats"}, got.size(), vecs[v].exp_beats);
      if (got.size() != 0) begin
        chk({vecs[v].nm, "_last_cnt"}, got[got.size()-1].cnt, vecs[v].exp_last_cnt);
        chk({vecs[v].nm, "_last_eop"}, got[got.size()-1].eop, 1);
      end
      chk({vecs[v].nm, "_throughput"}, cyc_used <= vecs[v].exp_total + 3, 1);
      compare_all(vecs[v].nm);
    end

    // TD header followed by another TLP: the DW after the MWr payload is the next header
    add_tlp(32'h4000_8001);
    add_tlp(32'h0000_0001);
    drain(100, 0, 200);
    if (got.size() == 2) begin
      chk("td_first_cnt", got[0].cnt, 4 + ECRC);
      chk("td_next_sop", got[1].sop, 1);
      chk("td_next_cnt", got[1].cnt, 3);
    end
    compare_all("td_pair");

    // Backpressure with two TLPs queued
    pops = 0;
    add_tlp(32'h6000_000A);
    add_tlp(32'h0000_0001);
    for (int i = 0; i < 20; i++) begin
      step(0, 0);
      if (i >= 15) chk("bp_rd_en_held", bus.rd_en, 0);
    end
    chk("bp_pops", pops, 14);
    drain(100, 0, 200);
    compare_all("bp");

    // Reset after header plus 4 payload DWs of a 14-DW TLP
    pops = 0;
    buf_q.push_back(32'h6000_000A);
    for (int i = 1; i < 14; i++) buf_q.push_back($urandom);
    cyc_used = 0;
    while (pops < 8 && cyc_used < 50) step(100, 0);
    chk("mid_rst_pops", pops, 8);
    do_reset();
    buf_q.delete();
    got.delete();
    exp_q.delete();
    add_tlp(32'h4000_0003);
    drain(100, 0, 200);
    compare_all("after_rst");

    // Random TLPs, random buffer gaps and downstream stalls
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 15; t++) begin
        h = $urandom;
        h[9:0] = 10'($urandom_range(24, 1));
        add_tlp(h);
      end
      drain(70, 25, 20000);
      compare_all("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
